// File: rtl/ad_trigger_capture_if.sv
// ad_trigger_capture_if: ADC capture control, status and readout bundle
interface ad_trigger_capture_if #(parameter int ADDR_W = 9);
  logic [7:0] addata;
  logic arm;
  logic trig_en;
  logic [7:0] trig_level;
  logic busy;
  logic done;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] cap_min;
  logic [7:0] cap_max;
  modport master (
    output addata, arm, trig_en, trig_level, rd_addr,
    input busy, done, rd_data, cap_min, cap_max
  );
  modport slave (
    input addata, arm, trig_en, trig_level, rd_addr,
    output busy, done, rd_data, cap_min, cap_max
  );
endinterface

// File: rtl/ad_trigger_capture.sv
// ad_trigger_capture: level-triggered ADC capture buffer with hysteresis and min/max
module ad_trigger_capture #(
  parameter int DEPTH = 512,
  parameter int ADDR_W = 9,
  parameter int HYST = 4
) (
  input logic clk,
  input logic rst,
  ad_trigger_capture_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_e;
  state_e state_q;
  logic [7:0] s0_q, min_q, max_q, rd_q;
  logic below_q, first_q, busy_q, done_q;
  logic [ADDR_W-1:0] wr_addr_q, waddr;
  logic [7:0] mem [DEPTH];
  logic [8:0] lo_w;
  logic [7:0] lo;
  logic trig, we;
  always_comb begin
    lo_w = {1'b0, bus.trig_level} - 9'(HYST);
    lo = lo_w[8] ? 8'h00 : lo_w[7:0];
    trig = bus.trig_en ? (below_q && s0_q >= bus.trig_level) : first_q;
    we = (state_q == ARMED && trig) || state_q == CAPTURE;
    waddr = state_q == ARMED ? '0 : wr_addr_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      s0_q <= 8'h00;
      below_q <= 1'b0;
      first_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wr_addr_q <= '0;
      min_q <= 8'hFF;
      max_q <= 8'h00;
    end else begin
      s0_q <= bus.addata;
      if (we) begin
        min_q <= s0_q < min_q ? s0_q : min_q;
        max_q <= s0_q > max_q ? s0_q : max_q;
      end
      case (state_q)
        IDLE, DONE: if (bus.arm) begin
          state_q <= ARMED;
          busy_q <= 1'b1;
          done_q <= 1'b0;
          below_q <= 1'b0;
          first_q <= 1'b1;
          min_q <= 8'hFF;
          max_q <= 8'h00;
        end
        ARMED: begin
          first_q <= 1'b0;
          below_q <= below_q | (s0_q <= lo);
          if (trig) begin
            state_q <= CAPTURE;
            wr_addr_q <= ADDR_W'(1);
          end
        end
        CAPTURE: begin
          // wr_addr wraps to 0 on the final write, ready for the next capture
          wr_addr_q <= wr_addr_q + 1'b1;
          if (wr_addr_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  // Buffer and read port have no reset so captured data survives rst
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= s0_q;
    rd_q <= mem[bus.rd_addr];
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.rd_data = rd_q;
  assign bus.cap_min = min_q;
  assign bus.cap_max = max_q;
endmodule

// File: tb/tb_ad_trigger_capture.sv
// tb_ad_trigger_capture: randomized and directed checks against a sample-history model
module tb_ad_trigger_capture;
  localparam int DEPTH = 512;
  localparam int ADDR_W = 9;
  localparam int HYST = 4;
  logic clk = 1'b0;
  logic rst;
  ad_trigger_capture_if #(.ADDR_W(ADDR_W)) bus ();
  ad_trigger_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HYST(HYST)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int n_vec = 0;
  int n_err = 0;
  int mode = 0;
  bit rd_fix = 0;
  int m_s0 = 0;
  bit m_armed = 0, m_trig = 0, m_done = 0;
  int q_arm[$];
  int cap_q[$];
  int mem_m[DEPTH];
  bit known[DEPTH];
  int rd_exp = 0;
  bit rd_ok = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int lo_of(input int lvl);
    return (lvl - HYST < 0) ? 0 : lvl - HYST;
  endfunction
  function automatic int clamp8(input int t);
    return t < 0 ? 0 : (t > 255 ? 255 : t);
  endfunction
  // Model: samples seen while armed decide the trigger; stored samples decide min/max
  task automatic model_step();
    int v, a, lvl, idx;
    bit fire, low;
    v = m_s0;
    a = int'(bus.rd_addr);
    lvl = int'(bus.trig_level);
    rd_ok = known[a];
    rd_exp = mem_m[a];
    if (rst) begin
      m_s0 = 0; m_armed = 0; m_trig = 0; m_done = 0;
      q_arm.delete(); cap_q.delete();
      return;
    end
    fire = 0;
    if (!m_armed) begin
      if (bus.arm) begin
        m_armed = 1; m_done = 0;
        q_arm.delete(); cap_q.delete();
      end
    end else if (!m_trig) begin
      low = 0;
      foreach (q_arm[i]) if (q_arm[i] <= lo_of(lvl)) low = 1;
      fire = bus.trig_en ? (low && v >= lvl) : (q_arm.size() == 0);
      if (fire) m_trig = 1;
      else q_arm.push_back(v);
    end else fire = 1;
    if (fire) begin
      idx = cap_q.size();
      if (idx == a) rd_ok = 0;
      mem_m[idx] = v;
      known[idx] = 1;
      cap_q.push_back(v);
      if (cap_q.size() == DEPTH) begin
        m_armed = 0; m_trig = 0; m_done = 1;
      end
    end
    m_s0 = int'(bus.addata);
  endtask
  task automatic compare();
    int mn, mx;
    mn = 255; mx = 0;
    foreach (cap_q[i]) begin
      if (cap_q[i] < mn) mn = cap_q[i];
      if (cap_q[i] > mx) mx = cap_q[i];
    end
    chk("busy", bus.busy, m_armed);
    chk("done", bus.done, m_done);
    chk("busy_done_excl", bus.busy & bus.done, 0);
    chk("cap_min", bus.cap_min, mn);
    chk("cap_max", bus.cap_max, mx);
    if (rd_ok) chk("rd_data", bus.rd_data, rd_exp);
  endtask
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
    if (mode == 1) bus.addata = bus.addata + 8'd1;
    else if (mode == 2) bus.addata = 8'($urandom);
    if (!rd_fix) bus.rd_addr = ADDR_W'($urandom);
  endtask
  task automatic arm_pulse();
    bus.arm = 1'b1;
    cycle();
    bus.arm = 1'b0;
  endtask
  task automatic wait_done(input int lim, output int n);
    n = 0;
    while (!bus.done && n < lim) begin
      cycle();
      n++;
    end
    chk("done_reached", bus.done, 1);
  endtask
  task automatic rd_lit(input int addr, input int exp, input string name);
    rd_fix = 1;
    bus.rd_addr = ADDR_W'(addr);
    cycle();
    chk(name, bus.rd_data, exp);
    rd_fix = 0;
  endtask
  initial begin
    int n, v0, lvl, d;
    int hyst_seq[7] = '{130, 126, 125, 124, 127, 128, 131};
    rst = 1'b1;
    bus.addata = 8'h00; bus.arm = 1'b0; bus.trig_en = 1'b0;
    bus.trig_level = 8'd128; bus.rd_addr = '0;
    #2;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_min", bus.cap_min, 8'hFF);
    chk("reset_max", bus.cap_max, 8'h00);
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    // free-running ramp capture
    mode = 1;
    bus.trig_en = 1'b0;
    v0 = int'(bus.addata);
    arm_pulse();
    chk("arm_busy", bus.busy, 1);
    wait_done(600, n);
    chk("freerun_latency", n, 512);
    mode = 0;
    chk("freerun_min", bus.cap_min, 8'h00);
    chk("freerun_max", bus.cap_max, 8'hFF);
    rd_lit(0, v0 % 256, "ramp_addr0");
    rd_lit(1, (v0 + 1) % 256, "ramp_addr1");
    rd_lit(300, (v0 + 300) % 256, "ramp_addr300");
    rd_lit(511, (v0 + 511) % 256, "ramp_addr511");
    // hysteresis crossing
    bus.trig_en = 1'b1; bus.trig_level = 8'd128; bus.addata = 8'd130;
    arm_pulse();
    foreach (hyst_seq[i]) begin
      bus.addata = 8'(hyst_seq[i]);
      cycle();
    end
    wait_done(600, n);
    rd_lit(0, 128, "hyst_addr0");
    rd_lit(1, 131, "hyst_addr1");
    // noise that never dips to lo must not trigger
    bus.addata = 8'd127;
    arm_pulse();
    for (int i = 0; i < 2000; i++) begin
      bus.addata = (i % 2) ? 8'd129 : 8'd127;
      cycle();
    end
    chk("noise_busy", bus.busy, 1);
    chk("noise_done", bus.done, 0);
    chk("noise_min", bus.cap_min, 8'hFF);
    bus.addata = 8'd120; cycle();
    bus.addata = 8'd200; cycle();
    wait_done(600, n);
    rd_lit(0, 200, "noise_addr0");
    // asynchronous reset mid-capture
    mode = 2;
    bus.trig_en = 1'b0;
    arm_pulse();
    for (int i = 0; i < 100; i++) cycle();
    rst = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_min", bus.cap_min, 8'hFF);
    chk("midrst_max", bus.cap_max, 8'h00);
    cycle();
    rst = 1'b0;
    cycle();
    arm_pulse();
    wait_done(600, n);
    chk("postrst_latency", n, 512);
    // arm ignored during capture
    arm_pulse();
    n = 0;
    while (!bus.done && n < 600) begin
      bus.arm = (n % 37 == 5);
      cycle();
      n++;
    end
    bus.arm = 1'b0;
    chk("ignore_latency", n, 512);
    // re-arm from DONE with constant input
    mode = 0;
    bus.addata = 8'h55;
    arm_pulse();
    chk("rearm_done", bus.done, 0);
    chk("rearm_busy", bus.busy, 1);
    chk("rearm_min", bus.cap_min, 8'hFF);
    chk("rearm_max", bus.cap_max, 8'h00);
    wait_done(600, n);
    chk("const_min", bus.cap_min, 8'h55);
    chk("const_max", bus.cap_max, 8'h55);
    // randomized traffic
    for (int i = 0; i < 6000; i++) begin
      if (!m_armed && $urandom_range(0, 9) == 0) begin
        bus.trig_en = ($urandom_range(0, 3) != 0);
        bus.trig_level = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, HYST)) : 8'($urandom);
      end
      bus.arm = ($urandom_range(0, 29) == 0);
      lvl = int'(bus.trig_level);
      d = int'($urandom_range(0, 24));
      bus.addata = $urandom_range(0, 1) ? 8'($urandom) : 8'(clamp8(lvl + d - 12));
      cycle();
    end
    bus.arm = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
